// File: rtl/demux_1to2_64bit_buf.sv
// demux_1to2_64bit_buf
//   Buffered 1-to-2 steering demux for 64-bit datapath words. One input
//   stream is routed by in_sel into one of two independent 2-entry FIFOs,
//   so a stalled consumer never blocks words bound for the other channel.
//   Order is preserved within a channel only.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_data/in_sel/in_valid  word, destination channel, qualifier
//   in_ready               selected channel has room (registered state only)
//   outN_data/outN_valid   head word of channel N and its qualifier
//   outN_ready             consumer N takes the head this cycle
//   outN_count             channel N occupancy, 0..2

// One channel: 2-entry FIFO, 1-bit pointers, count is the full/empty truth.
module demux_1to2_chan #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count,
  output logic             full
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  rptr, wptr;
  logic [1:0]            cnt;
  logic [WIDTH-1:0]      hold;

  // When empty the head is stale storage, so present the last shown word.
  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign count = cnt;
  assign rdata = valid ? mem[rptr] : hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= 2'd0;
      hold <= '0;
    end else begin
      hold <= rdata;
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      // push and pop together only happens at count 1: count is unchanged
      if (push && !pop)      cnt <= cnt + 2'd1;
      else if (pop && !push) cnt <= cnt - 2'd1;
    end
  end
endmodule

module demux_1to2_64bit_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [1:0]       out0_count,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [1:0]       out1_count
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0][1:0]       ch_count;
  logic [NUM_CH-1:0]            ch_valid, ch_full, ch_ready, ch_push, ch_pop;

  assign ch_ready = {out1_ready, out0_ready};

  // No pass-through: a full channel refuses even if it pops this cycle.
  assign in_ready = ~ch_full[in_sel];

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_push[i] = in_valid && in_ready && (in_sel == 1'(i));
      assign ch_pop[i]  = ch_valid[i] && ch_ready[i];

      demux_1to2_chan #(.WIDTH(WIDTH)) u_chan (
        .clk   (clk),
        .reset (reset),
        .push  (ch_push[i]),
        .wdata (in_data),
        .pop   (ch_pop[i]),
        .rdata (ch_data[i]),
        .valid (ch_valid[i]),
        .count (ch_count[i]),
        .full  (ch_full[i])
      );
    end
  endgenerate

  assign out0_data  = ch_data[0];
  assign out0_valid = ch_valid[0];
  assign out0_count = ch_count[0];
  assign out1_data  = ch_data[1];
  assign out1_valid = ch_valid[1];
  assign out1_count = ch_count[1];
endmodule

// File: tb/tb_demux_1to2_64bit_buf.sv
module tb_demux_1to2_64bit_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [63:0] out0_data, out1_data;
  logic        out0_valid, out1_valid, out0_ready, out1_ready;
  logic [1:0]  out0_count, out1_count;

  int nvec = 0;
  int nerr = 0;

  // scoreboard: expected words per channel, plus last head shown
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] last0, last1;

  demux_1to2_64bit_buf #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_count(out0_count),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check at negedge against the model, advance the model.
  task automatic cyc(input bit rst, input bit v, input bit sel, input logic [63:0] d,
                     input bit r0, input bit r1, output bit acc);
    int c0, c1;
    reset = rst; in_valid = v; in_sel = sel; in_data = d;
    out0_ready = r0; out1_ready = r1;
    @(negedge clk);
    c0 = q0.size(); c1 = q1.size();
    chk("in_ready",   64'(in_ready),   64'(((sel ? c1 : c0) != 2)));
    chk("out0_count", 64'(out0_count), 64'(c0));
    chk("out1_count", 64'(out1_count), 64'(c1));
    chk("out0_valid", 64'(out0_valid), 64'(c0 != 0));
    chk("out1_valid", 64'(out1_valid), 64'(c1 != 0));
    chk("out0_data",  out0_data, (c0 != 0) ? q0[0] : last0);
    chk("out1_data",  out1_data, (c1 != 0) ? q1[0] : last1);
    acc = !rst && v && ((sel ? c1 : c0) != 2);
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); last0 = '0; last1 = '0;
    end else begin
      if (c0 != 0) last0 = q0[0];
      if (c1 != 0) last1 = q1[0];
      if (c0 != 0 && r0) void'(q0.pop_front());
      if (c1 != 0 && r1) void'(q1.pop_front());
      if (acc) begin
        if (sel) q1.push_back(d); else q0.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    bit a;
    last0 = '0; last1 = '0;
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, both selects
    cyc(0, 0, 0, 64'h0, 1, 1, a);
    cyc(0, 0, 1, 64'h0, 1, 1, a);

    // basic routing
    cyc(0, 1, 0, 64'd2, 1, 1, a);
    cyc(0, 1, 1, 64'd3, 1, 1, a);
    repeat (3) cyc(0, 0, 0, 64'h0, 1, 1, a);

    // fill channel 0 and backpressure; 8 is refused
    cyc(0, 1, 0, 64'd6, 0, 1, a);
    cyc(0, 1, 0, 64'd7, 0, 1, a);
    cyc(0, 1, 0, 64'd8, 0, 1, a);
    chk("push8_refused", 64'(a), 64'd0);
    cyc(0, 0, 1, 64'h0, 0, 1, a);

    // isolation: channel 1 streams while channel 0 is stalled full
    cyc(0, 1, 1, 64'd10, 0, 1, a);
    cyc(0, 1, 1, 64'd11, 0, 1, a);
    cyc(0, 1, 1, 64'd12, 0, 1, a);
    chk("push12_accepted", 64'(a), 64'd1);
    repeat (2) cyc(0, 0, 0, 64'h0, 0, 1, a);

    // release channel 0: 8 refused while full even with pop, then taken
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 64'd8, 1, 1, a);
      if (a) break;
    end
    chk("push8_accepted", 64'(a), 64'd1);
    repeat (4) cyc(0, 0, 0, 64'h0, 1, 1, a);

    // full with pop, no pass-through
    cyc(0, 1, 0, 64'd6, 0, 1, a);
    cyc(0, 1, 0, 64'd7, 0, 1, a);
    cyc(0, 1, 0, 64'd9, 1, 1, a);
    chk("push9_refused", 64'(a), 64'd0);
    cyc(0, 1, 0, 64'd9, 1, 1, a);
    chk("push9_accepted", 64'(a), 64'd1);
    repeat (3) cyc(0, 0, 0, 64'h0, 1, 1, a);

    // simultaneous push/pop at count 1, pointer wrap
    cyc(0, 1, 1, 64'd20, 1, 0, a);
    for (int k = 21; k <= 29; k++) cyc(0, 1, 1, 64'(k), 1, 1, a);
    repeat (3) cyc(0, 0, 1, 64'h0, 1, 1, a);

    // wide data patterns pass bit-exact
    cyc(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, a);
    cyc(0, 1, 1, 64'h8000_0000_0000_0001, 1, 1, a);
    repeat (2) cyc(0, 0, 0, 64'h0, 1, 1, a);

    // reset mid-operation with both channels full and a push attempt
    cyc(0, 1, 0, 64'd30, 0, 0, a);
    cyc(0, 1, 0, 64'd31, 0, 0, a);
    cyc(0, 1, 1, 64'd32, 0, 0, a);
    cyc(0, 1, 1, 64'd33, 0, 0, a);
    cyc(1, 1, 1, 64'd99, 1, 1, a);
    cyc(0, 0, 0, 64'h0, 1, 1, a);
    cyc(0, 0, 1, 64'h0, 1, 1, a);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
